// File: rtl/bit_balance_pkg.sv
// Shared types and sizing helpers for the bit-balance frame controller.
package bit_balance_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int cnt_width(input int max_bytes);
    return $clog2(max_bytes * BYTE_BITS + 1);
  endfunction

  function automatic int byte_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/byte_ones_counter.sv
// Combinational popcount of one byte.
module byte_ones_counter
  import bit_balance_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] ones
);

  // Sum the set bits of the byte.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < BYTE_BITS; i++) begin
      ones = ones + {3'b000, data[i]};
    end
  end

endmodule

// File: rtl/bit_balance_frame_ctrl.sv
// Per-frame ones/zeros/byte statistics over a valid/ready byte stream.
module bit_balance_frame_ctrl
  import bit_balance_pkg::*;
#(
  parameter  int MAX_BYTES = 16,
  localparam int CNT_W     = cnt_width(MAX_BYTES),
  localparam int BYTE_W    = byte_width(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_ones,
  output logic [CNT_W-1:0]  out_zeros,
  output logic [BYTE_W-1:0] out_bytes,
  output logic              out_balanced,
  output logic              out_overflow
);

  localparam logic [BYTE_W-1:0] MAX_CNT = BYTE_W'(MAX_BYTES);
  localparam logic [BYTE_W-1:0] ONE_CNT = BYTE_W'(1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [3:0]        pop_s;
  logic              beat_acc_s;
  logic              out_acc_s;
  logic              room_s;
  logic [CNT_W-1:0]  ones_nxt_s;
  logic [CNT_W-1:0]  zeros_nxt_s;
  logic [BYTE_W-1:0] cnt_nxt_s;
  logic              ovf_nxt_s;

  logic [CNT_W-1:0]  ones_acc_r;
  logic [BYTE_W-1:0] byte_cnt_r;
  logic              ovf_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  out_ones_r;
  logic [CNT_W-1:0]  out_zeros_r;
  logic [BYTE_W-1:0] out_bytes_r;
  logic              out_balanced_r;
  logic              out_overflow_r;

  byte_ones_counter u_pop (
    .data (in_data),
    .ones (pop_s)
  );

  // Handshakes and the accumulator values after the current beat.
  always_comb begin
    beat_acc_s = in_valid && in_ready_r;
    out_acc_s  = out_valid_r && out_ready;
    room_s     = (byte_cnt_r < MAX_CNT);
    if (room_s) begin
      ones_nxt_s = ones_acc_r + CNT_W'(pop_s);
      cnt_nxt_s  = byte_cnt_r + ONE_CNT;
      ovf_nxt_s  = ovf_r;
    end else begin
      ones_nxt_s = ones_acc_r;
      cnt_nxt_s  = byte_cnt_r;
      ovf_nxt_s  = 1'b1;
    end
    zeros_nxt_s = CNT_W'({cnt_nxt_s, 3'b000}) - ones_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (beat_acc_s && in_last) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_acc_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulators and registered results; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_acc_r     <= '0;
      byte_cnt_r     <= '0;
      ovf_r          <= 1'b0;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_ones_r     <= '0;
      out_zeros_r    <= '0;
      out_bytes_r    <= '0;
      out_balanced_r <= 1'b0;
      out_overflow_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ACCUM);
      out_valid_r <= (state_nxt_s == HOLD);
      if (beat_acc_s) begin
        if (in_last) begin
          out_ones_r     <= ones_nxt_s;
          out_zeros_r    <= zeros_nxt_s;
          out_bytes_r    <= cnt_nxt_s;
          out_balanced_r <= (ones_nxt_s == zeros_nxt_s);
          out_overflow_r <= ovf_nxt_s;
          ones_acc_r     <= '0;
          byte_cnt_r     <= '0;
          ovf_r          <= 1'b0;
        end else begin
          ones_acc_r <= ones_nxt_s;
          byte_cnt_r <= cnt_nxt_s;
          ovf_r      <= ovf_nxt_s;
        end
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_ones     = out_ones_r;
  assign out_zeros    = out_zeros_r;
  assign out_bytes    = out_bytes_r;
  assign out_balanced = out_balanced_r;
  assign out_overflow = out_overflow_r;

endmodule

// File: tb/tb_bit_balance_frame_ctrl.sv
// Directed self-checking bench for bit_balance_frame_ctrl.
module tb_bit_balance_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ones;
  logic [7:0] out_zeros;
  logic [4:0] out_bytes;
  logic       out_balanced;
  logic       out_overflow;

  int errors = 0;
  int checks = 0;

  bit_balance_frame_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ones     (out_ones),
    .out_zeros    (out_zeros),
    .out_bytes    (out_bytes),
    .out_balanced (out_balanced),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check_eq("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int ones, input int zeros,
                             input int bytes, input int bal, input int ovf);
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_ones"}, int'(out_ones), ones);
    check_eq({tag, "_zeros"}, int'(out_zeros), zeros);
    check_eq({tag, "_bytes"}, int'(out_bytes), bytes);
    check_eq({tag, "_bal"}, int'(out_balanced), bal);
    check_eq({tag, "_ovf"}, int'(out_overflow), ovf);
    check_eq({tag, "_inrdy_hold"}, int'(in_ready), 0);
  endtask

  // With out_ready high, the result is taken on the next edge.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    check_eq({tag, "_valid_drop"}, int'(out_valid), 0);
    check_eq({tag, "_inrdy_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_inrdy", int'(in_ready), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_ones", int'(out_ones), 0);
    check_eq("rst_bytes", int'(out_bytes), 0);
    rst = 1'b0;
    tick();
    check_eq("rel_inrdy", int'(in_ready), 1);

    // Single byte, balanced.
    send_beat(8'hF0, 1'b1);
    check_frame("f1", 4, 4, 1, 1, 0);
    drain("f1");

    send_beat(8'hFF, 1'b0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h00, 1'b1);
    check_frame("f2", 9, 15, 3, 0, 0);
    drain("f2");

    // Backpressure: result must hold while a stray beat is offered.
    out_ready = 1'b0;
    send_beat(8'hAA, 1'b0);
    send_beat(8'h55, 1'b1);
    check_frame("f3", 8, 8, 2, 1, 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("f3_hold_ones", int'(out_ones), 8);
      check_eq("f3_hold_valid", int'(out_valid), 1);
      check_eq("f3_hold_inrdy", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("f3_valid_drop", int'(out_valid), 0);
    check_eq("f3_inrdy_back", int'(in_ready), 1);

    // Overflow: 18 bytes, only 16 counted.
    for (int i = 0; i < 18; i++) send_beat(8'hFF, (i == 17));
    check_frame("f4", 128, 0, 16, 0, 1);
    drain("f4");
    send_beat(8'h0F, 1'b1);
    check_frame("f5", 4, 4, 1, 1, 0);
    drain("f5");

    // Reset mid-frame drops the partial frame.
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_valid", int'(out_valid), 0);
    check_eq("mid_rst_inrdy", int'(in_ready), 0);
    rst = 1'b0;
    tick();
    check_eq("mid_rel_valid", int'(out_valid), 0);
    send_beat(8'h03, 1'b1);
    check_frame("f6", 2, 6, 1, 0, 0);
    drain("f6");

    // Idle cycle between every beat.
    send_beat(8'h01, 1'b0);
    tick();
    send_beat(8'h03, 1'b0);
    tick();
    send_beat(8'h07, 1'b1);
    check_frame("f7", 6, 18, 3, 0, 0);
    drain("f7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
